tc_fetch_sequencer: RTL and testbench

Instruction-fetch controller for the 4-byte-wide program ROM: owns the program counter, drives the ROM address, and packs the four returned bytes into one 32-bit instruction word. Instructions go to the decoder through a valid/ready handshake. It handles start, jump redirects (flush) and a halt opcode, and keeps a count of accepted instructions. It sits between the program ROM and the core's decode stage.

---
 rtl/tc_fetch_sequencer.sv | 117 +++++++++++
 tb/tb_tc_fetch_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tc_fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the 4-byte program ROM and
// presents packed 32-bit words to decode over valid/ready, with jump flush and halt.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RUN    | fetching one word per free output slot
// DRAIN  | halt word captured, waiting for decode to accept it
// HALTED | halt word accepted, waiting for start
module tc_fetch_sequencer #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned STEP        = 4,
   parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_b0,
   input  logic [7:0]        mem_b1,
   input  logic [7:0]        mem_b2,
   input  logic [7:0]        mem_b3,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              jump_valid,
   input  logic [ADDR_W-1:0] jump_target,
   output logic              running,
   output logic              halted,
   output logic [15:0]       instr_count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_HALTED = 2'd3;

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [31:0]       r_instr;
   logic [ADDR_W-1:0] r_instr_pc;
   logic              r_valid;
   logic [15:0]       r_count;

   logic w_accept;
   logic w_slot_free;
   logic w_start_ok;
   logic w_is_halt;

   assign w_accept    = r_valid && instr_ready;
   assign w_slot_free = !r_valid || instr_ready;
   assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_HALTED));
   assign w_is_halt   = (mem_b0 == HALT_OPCODE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
         r_count    <= '0;
      end else begin
         // A restart clears the count; acceptance in the same cycle is impossible
         // because the slot is always empty in IDLE and HALTED.
         if (w_start_ok)
            r_count <= '0;
         else if (w_accept && (r_count != 16'hFFFF))
            r_count <= r_count + 16'd1;

         case (r_state)
            S_IDLE, S_HALTED: begin
               if (start) begin
                  r_pc    <= start_addr;
                  r_valid <= 1'b0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (jump_valid) begin
                  r_pc    <= jump_target;
                  r_valid <= 1'b0;
               end else if (w_slot_free) begin
                  r_instr    <= {mem_b3, mem_b2, mem_b1, mem_b0};
                  r_instr_pc <= r_pc;
                  r_valid    <= 1'b1;
                  if (w_is_halt)
                     r_state <= S_DRAIN;
                  else
                     r_pc <= r_pc + ADDR_W'(STEP);
               end
            end
            S_DRAIN: begin
               if (jump_valid) begin
                  r_pc    <= jump_target;
                  r_valid <= 1'b0;
                  r_state <= S_RUN;
               end else if (w_accept) begin
                  r_valid <= 1'b0;
                  r_state <= S_HALTED;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_addr    = r_pc;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_valid;
   assign instr_count = r_count;
   assign running     = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_tc_fetch_sequencer.sv
// Directed bench for tc_fetch_sequencer: ROM model returns byte value = address,
// with an optional halt opcode planted at one address.
module tb_tc_fetch_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  start_addr;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_b0, mem_b1, mem_b2, mem_b3;
   logic [31:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump_valid;
   logic [7:0]  jump_target;
   logic        running;
   logic        halted;
   logic [15:0] instr_count;

   logic        halt_on;
   logic [7:0]  halt_addr;

   int checks = 0;
   int errors = 0;

   tc_fetch_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .mem_addr   (mem_addr),
      .mem_b0     (mem_b0),
      .mem_b1     (mem_b1),
      .mem_b2     (mem_b2),
      .mem_b3     (mem_b3),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .jump_valid (jump_valid),
      .jump_target(jump_target),
      .running    (running),
      .halted     (halted),
      .instr_count(instr_count)
   );

   assign mem_b0 = (halt_on && mem_addr == halt_addr) ? 8'hFF : mem_addr;
   assign mem_b1 = mem_addr + 8'd1;
   assign mem_b2 = mem_addr + 8'd2;
   assign mem_b3 = mem_addr + 8'd3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start_addr = 8'h00; instr_ready = 1'b1;
      jump_valid = 1'b0; jump_target = 8'h00; halt_on = 1'b0; halt_addr = 8'h0C;
      tick(); tick();
      check("rst_mem_addr", 32'(mem_addr), 32'h00);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", 32'(instr_pc), 32'h00);
      check("rst_count", 32'(instr_count), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);

      // linear fetch from 0
      rst = 1'b0; start = 1'b1; start_addr = 8'h00;
      tick();
      start = 1'b0;
      check("start_mem_addr", 32'(mem_addr), 32'h00);
      check("start_valid", 32'(instr_valid), 32'd0);
      check("start_running", 32'(running), 32'd1);
      tick();
      check("lin0_instr", instr, 32'h03020100);
      check("lin0_pc", 32'(instr_pc), 32'h00);
      check("lin0_valid", 32'(instr_valid), 32'd1);
      tick();
      check("lin1_instr", instr, 32'h07060504);
      check("lin1_pc", 32'(instr_pc), 32'h04);
      check("lin1_count", 32'(instr_count), 32'd1);

      // backpressure while word 0x04 is presented
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_instr", instr, 32'h07060504);
         check("bp_pc", 32'(instr_pc), 32'h04);
         check("bp_mem_addr", 32'(mem_addr), 32'h08);
         check("bp_valid", 32'(instr_valid), 32'd1);
         check("bp_count", 32'(instr_count), 32'd1);
      end
      instr_ready = 1'b1;
      tick();
      check("lin2_instr", instr, 32'h0B0A0908);
      check("lin2_pc", 32'(instr_pc), 32'h08);
      check("lin2_count", 32'(instr_count), 32'd2);
      tick();
      check("lin3_pc", 32'(instr_pc), 32'h0C);
      check("lin3_count", 32'(instr_count), 32'd3);
      tick();
      check("lin4_pc", 32'(instr_pc), 32'h10);
      check("lin4_count", 32'(instr_count), 32'd4);

      // jump while word 0x10 is accepted
      jump_valid = 1'b1; jump_target = 8'h40;
      tick();
      jump_valid = 1'b0;
      check("jmp_bubble", 32'(instr_valid), 32'd0);
      check("jmp_mem_addr", 32'(mem_addr), 32'h40);
      check("jmp_count", 32'(instr_count), 32'd5);
      tick();
      check("jmp_tgt_pc", 32'(instr_pc), 32'h40);
      check("jmp_tgt_instr", instr, 32'h43424140);
      check("jmp_tgt_valid", 32'(instr_valid), 32'd1);
      tick();
      check("jmp_next_pc", 32'(instr_pc), 32'h44);
      check("jmp_next_count", 32'(instr_count), 32'd6);

      // halt at 0x0C, reached via a jump to 0x08
      halt_on = 1'b1; halt_addr = 8'h0C;
      jump_valid = 1'b1; jump_target = 8'h08;
      tick();
      jump_valid = 1'b0;
      check("h_count_a", 32'(instr_count), 32'd7);
      tick();
      check("h_pre_pc", 32'(instr_pc), 32'h08);
      tick();
      check("h_instr", instr, 32'h0F0E0DFF);
      check("h_pc", 32'(instr_pc), 32'h0C);
      check("h_valid", 32'(instr_valid), 32'd1);
      check("h_mem_addr", 32'(mem_addr), 32'h0C);
      check("h_count_b", 32'(instr_count), 32'd8);
      instr_ready = 1'b0;
      tick();
      check("drain_valid", 32'(instr_valid), 32'd1);
      check("drain_halted", 32'(halted), 32'd0);
      check("drain_running", 32'(running), 32'd1);
      check("drain_mem_addr", 32'(mem_addr), 32'h0C);
      instr_ready = 1'b1;
      tick();
      check("halt_valid", 32'(instr_valid), 32'd0);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_running", 32'(running), 32'd0);
      check("halt_count", 32'(instr_count), 32'd9);
      jump_valid = 1'b1; jump_target = 8'h60;
      tick();
      jump_valid = 1'b0;
      check("halt_jmp_ign", 32'(halted), 32'd1);
      check("halt_jmp_addr", 32'(mem_addr), 32'h0C);
      start = 1'b1; start_addr = 8'h20;
      tick();
      start = 1'b0;
      check("restart_addr", 32'(mem_addr), 32'h20);
      check("restart_count", 32'(instr_count), 32'd0);
      check("restart_halted", 32'(halted), 32'd0);
      tick();
      check("restart_pc", 32'(instr_pc), 32'h20);
      check("restart_instr", instr, 32'h23222120);

      // halt word at 0x28 flushed by a jump while stalled
      halt_addr = 8'h28;
      tick();
      check("fh_pc24", 32'(instr_pc), 32'h24);
      check("fh_count", 32'(instr_count), 32'd1);
      tick();
      check("fh_instr", instr, 32'h2B2A29FF);
      instr_ready = 1'b0; jump_valid = 1'b1; jump_target = 8'h80;
      tick();
      jump_valid = 1'b0; instr_ready = 1'b1;
      check("fh_valid", 32'(instr_valid), 32'd0);
      check("fh_mem_addr", 32'(mem_addr), 32'h80);
      check("fh_halted", 32'(halted), 32'd0);
      check("fh_running", 32'(running), 32'd1);
      check("fh_count_kept", 32'(instr_count), 32'd2);
      tick();
      check("fh_tgt_pc", 32'(instr_pc), 32'h80);
      check("fh_tgt_valid", 32'(instr_valid), 32'd1);
      tick();
      check("fh_next_pc", 32'(instr_pc), 32'h84);

      // wrap-around from 0xFC
      jump_valid = 1'b1; jump_target = 8'hFC;
      tick();
      jump_valid = 1'b0;
      check("wrap_mem_addr", 32'(mem_addr), 32'hFC);
      tick();
      check("wrap_pc_fc", 32'(instr_pc), 32'hFC);
      check("wrap_instr_fc", instr, 32'hFFFEFDFC);
      tick();
      check("wrap_pc_00", 32'(instr_pc), 32'h00);
      check("wrap_instr_00", instr, 32'h03020100);

      // reset mid-stream with concurrent start and jump
      rst = 1'b1; start = 1'b1; start_addr = 8'h50; jump_valid = 1'b1; jump_target = 8'h70;
      tick();
      rst = 1'b0; start = 1'b0; jump_valid = 1'b0;
      check("mrst_mem_addr", 32'(mem_addr), 32'h00);
      check("mrst_valid", 32'(instr_valid), 32'd0);
      check("mrst_count", 32'(instr_count), 32'd0);
      check("mrst_running", 32'(running), 32'd0);
      check("mrst_halted", 32'(halted), 32'd0);
      check("mrst_instr", instr, 32'h0);
      tick();
      check("idle_mem_addr", 32'(mem_addr), 32'h00);
      check("idle_running", 32'(running), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
